// File: rtl/ir_encoder.sv
// Four-source interrupt encoder: latches request edges, applies mask, fixed
// priority and in-service nesting, and presents one registered code to the CPU.
module ir_encoder (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [3:0] in_req,
  input  logic [3:0] in_mask,
  input  logic       in_ie,
  input  logic       in_ack,
  input  logic       in_eoi,
  output logic       out_int,
  output logic [1:0] out_code,
  output logic [3:0] out_pending,
  output logic [3:0] out_inserv
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] code_nx;

  logic [3:0] req_d;
  logic [3:0] pending;
  logic [3:0] inserv;

  logic [3:0] rise;
  logic [3:0] cand;
  logic [3:0] below;
  logic [3:0] eligible;
  logic       any_eligible;
  logic [1:0] best;
  logic       ack_ok;
  logic [3:0] ack_clr;
  logic [3:0] ack_set;
  logic [3:0] eoi_clr;
  logic [3:0] pending_nx;
  logic [3:0] inserv_nx;

  assign rise = in_req & ~req_d;
  assign cand = pending & ~in_mask;

  // Only sources strictly higher in priority than the lowest-index in-service
  // source may interrupt; with nothing in service every source qualifies.
  always_comb begin
    below = 4'b1111;
    if (inserv[0])      below = 4'b0000;
    else if (inserv[1]) below = 4'b0001;
    else if (inserv[2]) below = 4'b0011;
    else if (inserv[3]) below = 4'b0111;
  end

  assign eligible     = cand & below;
  assign any_eligible = |eligible;

  always_comb begin
    best = 2'd0;
    if (eligible[0])      best = 2'd0;
    else if (eligible[1]) best = 2'd1;
    else if (eligible[2]) best = 2'd2;
    else if (eligible[3]) best = 2'd3;
  end

  // Handshake: out_int/out_code form a request that stays stable while out_int
  // is high; in_ack is a single-cycle accept that only counts while out_int is
  // high. Dropping in_ie withdraws an unaccepted request, and the source stays
  // pending.
  assign ack_ok  = (state == REQ) && in_ack;
  assign ack_clr = ack_ok ? (4'b0001 << out_code) : 4'b0000;
  assign ack_set = ack_clr;

  // Lowest set bit of the pre-update inserv; zero when nothing is in service.
  assign eoi_clr = in_eoi ? (inserv & (~inserv + 4'd1)) : 4'b0000;

  assign pending_nx = (pending & ~ack_clr) | rise;
  assign inserv_nx  = (inserv & ~eoi_clr) | ack_set;

  always_comb begin
    state_nx = state;
    code_nx  = out_code;
    case (state)
      IDLE: begin
        if (in_ie && any_eligible) begin
          code_nx  = best;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (in_ack) begin
          state_nx = IDLE;
        end else if (!in_ie) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= IDLE;
      out_int  <= 1'b0;
      out_code <= 2'b00;
      req_d    <= 4'b0000;
      pending  <= 4'b0000;
      inserv   <= 4'b0000;
    end else begin
      state    <= state_nx;
      out_int  <= (state_nx == REQ);
      out_code <= code_nx;
      req_d    <= in_req;
      pending  <= pending_nx;
      inserv   <= inserv_nx;
    end
  end

  assign out_pending = pending;
  assign out_inserv  = inserv;

endmodule

// File: tb/tb_ir_encoder.sv
// Bench for ir_encoder: directed scenarios with fixed expectations, then a
// randomized run compared cycle by cycle against a behavioural model.
module tb_ir_encoder;

  logic       in_clk;
  logic       in_rst;
  logic [3:0] in_req;
  logic [3:0] in_mask;
  logic       in_ie;
  logic       in_ack;
  logic       in_eoi;
  logic       out_int;
  logic [1:0] out_code;
  logic [3:0] out_pending;
  logic [3:0] out_inserv;

  int checks;
  int errors;

  // behavioural model state
  logic       m_int;
  logic [1:0] m_code;
  logic [3:0] m_pend;
  logic [3:0] m_ins;
  logic [3:0] m_reqd;

  ir_encoder dut (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .in_req      (in_req),
    .in_mask     (in_mask),
    .in_ie       (in_ie),
    .in_ack      (in_ack),
    .in_eoi      (in_eoi),
    .out_int     (out_int),
    .out_code    (out_code),
    .out_pending (out_pending),
    .out_inserv  (out_inserv)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic model_step();
    int lo;
    int best;
    logic [3:0] np;
    logic [3:0] ni;
    if (in_rst) begin
      m_int = 1'b0; m_code = 2'b00; m_pend = 4'b0; m_ins = 4'b0; m_reqd = 4'b0;
      return;
    end
    lo = 4;
    for (int i = 3; i >= 0; i--) if (m_ins[i]) lo = i;
    best = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i] && !in_mask[i] && i < lo) best = i;
    np = m_pend;
    ni = m_ins;
    if (in_eoi && lo < 4) ni[lo] = 1'b0;
    if (m_int) begin
      if (in_ack) begin
        np[m_code] = 1'b0;
        ni[m_code] = 1'b1;
        m_int = 1'b0;
      end else if (!in_ie) begin
        m_int = 1'b0;
      end
    end else if (in_ie && best >= 0) begin
      m_int  = 1'b1;
      m_code = best[1:0];
    end
    for (int i = 0; i < 4; i++) if (in_req[i] && !m_reqd[i]) np[i] = 1'b1;
    m_pend = np;
    m_ins  = ni;
    m_reqd = in_req;
  endtask

  task automatic tick();
    @(posedge in_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    in_rst = 1'b1; in_req = 4'b0; in_mask = 4'b0; in_ie = 1'b0; in_ack = 1'b0; in_eoi = 1'b0;
    tick(); tick();
    in_rst = 1'b0;
    checks++; if (out_int !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", out_int); end
    checks++; if (out_code !== 2'b00) begin errors++; $display("FAIL reset_code got %0d want 0", out_code); end
    checks++; if (out_pending !== 4'b0) begin errors++; $display("FAIL reset_pend got %b want 0000", out_pending); end
    checks++; if (out_inserv !== 4'b0) begin errors++; $display("FAIL reset_ins got %b want 0000", out_inserv); end
  endtask

  task automatic test_single();
    in_ie = 1'b1; in_mask = 4'b0;
    tick(); tick();
    in_req = 4'b0100; tick();
    checks++; if (out_pending !== 4'b0100) begin errors++; $display("FAIL single_pend got %b want 0100", out_pending); end
    checks++; if (out_int !== 1'b0) begin errors++; $display("FAIL single_int_early got %b want 0", out_int); end
    in_req = 4'b0; tick();
    checks++; if (out_int !== 1'b1) begin errors++; $display("FAIL single_int got %b want 1", out_int); end
    checks++; if (out_code !== 2'd2) begin errors++; $display("FAIL single_code got %0d want 2", out_code); end
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    checks++; if (out_int !== 1'b0) begin errors++; $display("FAIL single_ack_int got %b want 0", out_int); end
    checks++; if (out_pending !== 4'b0) begin errors++; $display("FAIL single_ack_pend got %b want 0000", out_pending); end
    checks++; if (out_inserv !== 4'b0100) begin errors++; $display("FAIL single_ack_ins got %b want 0100", out_inserv); end
    in_eoi = 1'b1; tick(); in_eoi = 1'b0;
    checks++; if (out_inserv !== 4'b0) begin errors++; $display("FAIL single_eoi_ins got %b want 0000", out_inserv); end
  endtask

  task automatic test_priority_and_frozen();
    in_req = 4'b1010; tick(); in_req = 4'b0; tick();
    checks++; if (out_code !== 2'd1 || out_int !== 1'b1) begin errors++; $display("FAIL prio_code got int=%b code=%0d want int=1 code=1", out_int, out_code); end
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    in_req = 4'b0001; tick(); in_req = 4'b0; tick();
    checks++; if (out_code !== 2'd0 || out_int !== 1'b1) begin errors++; $display("FAIL nest_code got int=%b code=%0d want int=1 code=0", out_int, out_code); end
    checks++; if (out_inserv !== 4'b0010) begin errors++; $display("FAIL nest_ins got %b want 0010", out_inserv); end
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    checks++; if (out_inserv !== 4'b0011) begin errors++; $display("FAIL nest_ins2 got %b want 0011", out_inserv); end
    in_eoi = 1'b1; tick();
    checks++; if (out_inserv !== 4'b0010) begin errors++; $display("FAIL eoi1_ins got %b want 0010", out_inserv); end
    tick(); in_eoi = 1'b0;
    checks++; if (out_inserv !== 4'b0000 || out_int !== 1'b0) begin errors++; $display("FAIL eoi2 got ins=%b int=%b want ins=0000 int=0", out_inserv, out_int); end
    tick();
    checks++; if (out_code !== 2'd3 || out_int !== 1'b1) begin errors++; $display("FAIL after_eoi got int=%b code=%0d want int=1 code=3", out_int, out_code); end
    in_req = 4'b0001; tick();
    checks++; if (out_code !== 2'd3 || out_int !== 1'b1) begin errors++; $display("FAIL frozen got int=%b code=%0d want int=1 code=3", out_int, out_code); end
    in_req = 4'b0; in_ie = 1'b0; tick();
    checks++; if (out_int !== 1'b0 || out_pending !== 4'b1001) begin errors++; $display("FAIL withdraw got int=%b pend=%b want int=0 pend=1001", out_int, out_pending); end
    in_ie = 1'b1; tick();
    checks++; if (out_code !== 2'd0 || out_int !== 1'b1) begin errors++; $display("FAIL reenable got int=%b code=%0d want int=1 code=0", out_int, out_code); end
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    in_eoi = 1'b1; tick(); in_eoi = 1'b0;
    tick();
    checks++; if (out_code !== 2'd3 || out_int !== 1'b1) begin errors++; $display("FAIL drain3 got int=%b code=%0d want int=1 code=3", out_int, out_code); end
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    in_eoi = 1'b1; tick(); in_eoi = 1'b0;
    tick();
    checks++; if (out_pending !== 4'b0 || out_inserv !== 4'b0 || out_int !== 1'b0) begin errors++; $display("FAIL drain_idle got pend=%b ins=%b int=%b want 0000 0000 0", out_pending, out_inserv, out_int); end
  endtask

  task automatic test_nesting_block();
    in_req = 4'b0010; tick(); in_req = 4'b0; tick();
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    in_req = 4'b0100; tick(); in_req = 4'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_int !== 1'b0) begin errors++; $display("FAIL block_int cyc %0d got %b want 0", i, out_int); end
    end
    in_eoi = 1'b1; tick(); in_eoi = 1'b0;
    checks++; if (out_int !== 1'b0 || out_inserv !== 4'b0) begin errors++; $display("FAIL block_eoi got int=%b ins=%b want int=0 ins=0000", out_int, out_inserv); end
    tick();
    checks++; if (out_int !== 1'b1 || out_code !== 2'd2) begin errors++; $display("FAIL block_release got int=%b code=%0d want int=1 code=2", out_int, out_code); end
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    in_eoi = 1'b1; tick(); in_eoi = 1'b0;
  endtask

  task automatic test_mask();
    in_mask = 4'b0001; in_req = 4'b0001; tick(); in_req = 4'b0;
    tick(); tick();
    checks++; if (out_int !== 1'b0 || out_pending !== 4'b0001) begin errors++; $display("FAIL mask got int=%b pend=%b want int=0 pend=0001", out_int, out_pending); end
    in_mask = 4'b0; tick();
    checks++; if (out_int !== 1'b1 || out_code !== 2'd0) begin errors++; $display("FAIL unmask got int=%b code=%0d want int=1 code=0", out_int, out_code); end
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    in_eoi = 1'b1; tick(); in_eoi = 1'b0;
  endtask

  task automatic test_ack_eoi_same();
    in_req = 4'b0100; tick(); in_req = 4'b0; tick();
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    in_req = 4'b0010; tick(); in_req = 4'b0; tick();
    checks++; if (out_int !== 1'b1 || out_code !== 2'd1 || out_inserv !== 4'b0100) begin errors++; $display("FAIL same_setup got int=%b code=%0d ins=%b want 1 1 0100", out_int, out_code, out_inserv); end
    in_ack = 1'b1; in_eoi = 1'b1; tick(); in_ack = 1'b0; in_eoi = 1'b0;
    checks++; if (out_inserv !== 4'b0010) begin errors++; $display("FAIL ack_eoi_same got %b want 0010", out_inserv); end
    in_eoi = 1'b1; tick(); in_eoi = 1'b0;
  endtask

  task automatic test_reset_in_req();
    in_req = 4'b1000; tick(); in_req = 4'b0; tick();
    checks++; if (out_int !== 1'b1 || out_code !== 2'd3) begin errors++; $display("FAIL rst_setup got int=%b code=%0d want 1 3", out_int, out_code); end
    in_req = 4'b0100; in_rst = 1'b1; tick();
    checks++; if (out_int !== 1'b0 || out_code !== 2'd0 || out_pending !== 4'b0 || out_inserv !== 4'b0) begin errors++; $display("FAIL rst_req got int=%b code=%0d pend=%b ins=%b want 0 0 0000 0000", out_int, out_code, out_pending, out_inserv); end
    in_rst = 1'b0; tick();
    checks++; if (out_pending !== 4'b0100) begin errors++; $display("FAIL rst_held_line got %b want 0100", out_pending); end
    in_req = 4'b0; in_rst = 1'b1; tick(); in_rst = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    in_rst = 1'b1; tick(); in_rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) in_req = 4'($urandom_range(0, 15));
      in_mask = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      in_ie   = ($urandom_range(0, 9) != 0);
      in_ack  = ($urandom_range(0, 2) == 0);
      in_eoi  = ($urandom_range(0, 5) == 0);
      in_rst  = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (out_int !== m_int || out_code !== m_code || out_pending !== m_pend || out_inserv !== m_ins) begin
        errors++;
        bad++;
        if (bad <= 20)
          $display("FAIL random cyc %0d got int=%b code=%0d pend=%b ins=%b want int=%b code=%0d pend=%b ins=%b",
                   n, out_int, out_code, out_pending, out_inserv, m_int, m_code, m_pend, m_ins);
      end
    end
    in_ack = 1'b0; in_eoi = 1'b0; in_rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_int = 1'b0; m_code = 2'b00; m_pend = 4'b0; m_ins = 4'b0; m_reqd = 4'b0;
    test_reset();
    test_single();
    test_priority_and_frozen();
    test_nesting_block();
    test_mask();
    test_ack_eoi_same();
    test_reset_in_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
